// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, the "no register" id, status
// codes, and the values loaded into the E bank when a bubble is injected.
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Register id meaning "no register"
  localparam logic [3:0] RNONE = 4'hF;

  // Pipeline status codes
  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  // Bubble values for the E bank (a nop that can never raise an exception)
  localparam logic [3:0] BUB_ICODE = I_NOP;
  localparam logic [3:0] BUB_IFUN  = 4'h0;
  localparam logic [3:0] BUB_REG   = RNONE;
  localparam stat_e      BUB_STAT  = STAT_AOK;

  // Instructions whose result arrives from memory (valM) in the M stage
  function automatic logic is_load(input logic [3:0] icode);
    return (icode == I_MRMOVQ) || (icode == I_POPQ);
  endfunction

endpackage

// File: rtl/e_hazard_ctl.sv
// E-stage hazard detection (purely combinational).
// Ports:
//   E_icode, E_dstM  - instruction currently held in the E register
//   d_srcA, d_srcB   - source registers of the instruction in decode
//   e_Cnd            - branch condition of the instruction in E
//   mispredict_o     - jump in E was predicted taken but is not taken
//   load_use_o       - decode needs a value the load in E has not produced yet
//   bubble_o         - either hazard: inject a nop at the next edge
module e_hazard_ctl
  import y86_pkg::*;
(
  input  logic [3:0] E_icode,
  input  logic [3:0] E_dstM,
  input  logic [3:0] d_srcA,
  input  logic [3:0] d_srcB,
  input  logic       e_Cnd,
  output logic       mispredict_o,
  output logic       load_use_o,
  output logic       bubble_o
);

  always_comb begin
    mispredict_o = (E_icode == I_JXX) && !e_Cnd;
    // A load with no destination can never feed a later source
    load_use_o   = is_load(E_icode) && (E_dstM != RNONE) &&
                   ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    bubble_o     = mispredict_o || load_use_o;
  end

endmodule

// File: rtl/e_pipe_reg.sv
// Decode->Execute pipeline register for the Y86-64 5-stage core.
// Captures all decode outputs into the E bank each clock, with priority
// stall (hold) > bubble (load nop) > capture. Reset is asynchronous, active-low,
// and loads the bubble values.
// Ports:
//   clk, rst_n          - clock (rising edge), async active-low reset
//   d_*                 - decode-stage outputs to be captured
//   e_Cnd               - condition result of the instruction in E
//   E_stall             - hold the E bank
//   E_* (outputs)       - registered copies of the d_* inputs
//   E_bubble            - combinational: a bubble is loaded at the next edge
//   E_ctl_err           - sticky: stall and bubble requested in the same cycle
// Optional feature (macro E_BUBBLE_STATS_EN): adds saturating counters
//   lu_cnt / mp_cnt of load/use and mispredict bubbles actually loaded.
module e_pipe_reg
  import y86_pkg::*;
#(
  parameter int unsigned WORD_W = 64,
  parameter int unsigned STAT_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        d_icode,
  input  logic [3:0]        d_ifun,
  input  logic [WORD_W-1:0] d_valC,
  input  logic [WORD_W-1:0] d_valA,
  input  logic [WORD_W-1:0] d_valB,
  input  logic [3:0]        d_dstE,
  input  logic [3:0]        d_dstM,
  input  logic [3:0]        d_srcA,
  input  logic [3:0]        d_srcB,
  input  logic [STAT_W-1:0] d_stat,
  input  logic              e_Cnd,
  input  logic              E_stall,
  output logic [3:0]        E_icode,
  output logic [3:0]        E_ifun,
  output logic [WORD_W-1:0] E_valC,
  output logic [WORD_W-1:0] E_valA,
  output logic [WORD_W-1:0] E_valB,
  output logic [3:0]        E_dstE,
  output logic [3:0]        E_dstM,
  output logic [3:0]        E_srcA,
  output logic [3:0]        E_srcB,
  output logic [STAT_W-1:0] E_stat,
  output logic              E_bubble,
  output logic              E_ctl_err
`ifdef E_BUBBLE_STATS_EN
  ,
  output logic [31:0]       lu_cnt,
  output logic [31:0]       mp_cnt
`endif
);

  localparam logic [STAT_W-1:0] BUB_STAT_W = STAT_W'(BUB_STAT);

  logic [3:0]        icode_q, icode_d, ifun_q, ifun_d;
  logic [WORD_W-1:0] valc_q, valc_d, vala_q, vala_d, valb_q, valb_d;
  logic [3:0]        dste_q, dste_d, dstm_q, dstm_d;
  logic [3:0]        srca_q, srca_d, srcb_q, srcb_d;
  logic [STAT_W-1:0] stat_q, stat_d;
  logic              ctl_err_q, ctl_err_d;
  logic              mispredict, load_use, bubble;

  e_hazard_ctl u_hazard (
    .E_icode      (icode_q),
    .E_dstM       (dstm_q),
    .d_srcA       (d_srcA),
    .d_srcB       (d_srcB),
    .e_Cnd        (e_Cnd),
    .mispredict_o (mispredict),
    .load_use_o   (load_use),
    .bubble_o     (bubble)
  );

  always_comb begin
    icode_d = icode_q;  ifun_d = ifun_q;
    valc_d  = valc_q;   vala_d = vala_q;  valb_d = valb_q;
    dste_d  = dste_q;   dstm_d = dstm_q;
    srca_d  = srca_q;   srcb_d = srcb_q;
    stat_d  = stat_q;
    if (E_stall) begin
      // hold: defaults already keep every field
    end else if (bubble) begin
      icode_d = BUB_ICODE;  ifun_d = BUB_IFUN;
      valc_d  = '0;         vala_d = '0;       valb_d = '0;
      dste_d  = BUB_REG;    dstm_d = BUB_REG;
      srca_d  = BUB_REG;    srcb_d = BUB_REG;
      stat_d  = BUB_STAT_W;
    end else begin
      icode_d = d_icode;  ifun_d = d_ifun;
      valc_d  = d_valC;   vala_d = d_valA;  valb_d = d_valB;
      dste_d  = d_dstE;   dstm_d = d_dstM;
      srca_d  = d_srcA;   srcb_d = d_srcB;
      stat_d  = d_stat;
    end
    ctl_err_d = ctl_err_q || (E_stall && bubble);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icode_q   <= BUB_ICODE;  ifun_q <= BUB_IFUN;
      valc_q    <= '0;         vala_q <= '0;       valb_q <= '0;
      dste_q    <= BUB_REG;    dstm_q <= BUB_REG;
      srca_q    <= BUB_REG;    srcb_q <= BUB_REG;
      stat_q    <= BUB_STAT_W;
      ctl_err_q <= 1'b0;
    end else begin
      icode_q   <= icode_d;  ifun_q <= ifun_d;
      valc_q    <= valc_d;   vala_q <= vala_d;  valb_q <= valb_d;
      dste_q    <= dste_d;   dstm_q <= dstm_d;
      srca_q    <= srca_d;   srcb_q <= srcb_d;
      stat_q    <= stat_d;
      ctl_err_q <= ctl_err_d;
    end
  end

  assign E_icode   = icode_q;
  assign E_ifun    = ifun_q;
  assign E_valC    = valc_q;
  assign E_valA    = vala_q;
  assign E_valB    = valb_q;
  assign E_dstE    = dste_q;
  assign E_dstM    = dstm_q;
  assign E_srcA    = srca_q;
  assign E_srcB    = srcb_q;
  assign E_stat    = stat_q;
  assign E_bubble  = bubble;
  assign E_ctl_err = ctl_err_q;

`ifdef E_BUBBLE_STATS_EN
  logic [31:0] lu_q, lu_d, mp_q, mp_d;

  // Count only bubbles that are actually loaded (a stall suppresses them)
  always_comb begin
    lu_d = lu_q;
    mp_d = mp_q;
    if (!E_stall && load_use && (lu_q != '1)) lu_d = lu_q + 32'd1;
    if (!E_stall && mispredict && (mp_q != '1)) mp_d = mp_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_q <= '0;
      mp_q <= '0;
    end else begin
      lu_q <= lu_d;
      mp_q <= mp_d;
    end
  end

  assign lu_cnt = lu_q;
  assign mp_cnt = mp_q;
`endif

endmodule
